// File: rtl/calc_pkg.sv
// Shared opcodes, result codes and FSM encoding for the calculator op sequencer.
package calc_pkg;

  localparam int unsigned NUNITS = 5;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RC_W   = 2;
  localparam int unsigned WD_W   = 8;

  localparam logic [OP_W-1:0] OP_SUMA      = 3'd0;
  localparam logic [OP_W-1:0] OP_DIFERENTA = 3'd1;
  localparam logic [OP_W-1:0] OP_PRODUS    = 3'd2;
  localparam logic [OP_W-1:0] OP_IMPARTIRE = 3'd3;
  localparam logic [OP_W-1:0] OP_FACTORIAL = 3'd4;
  localparam logic [OP_W-1:0] OP_LAST      = 3'd4;

  // Opcode served by each unit index
  localparam logic [OP_W-1:0] UNIT_OP [NUNITS] =
    '{OP_SUMA, OP_DIFERENTA, OP_PRODUS, OP_IMPARTIRE, OP_FACTORIAL};

  localparam logic [RC_W-1:0] RC_OK      = 2'd0;
  localparam logic [RC_W-1:0] RC_ERR     = 2'd1;
  localparam logic [RC_W-1:0] RC_ILLEGAL = 2'd2;
  localparam logic [RC_W-1:0] RC_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Opcodes above OP_LAST have no unit behind them
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/calc_watchdog.sv
// WAIT-state watchdog: counts WAIT cycles and flags the last allowed one.
module calc_watchdog
  import calc_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [WD_W-1:0] cnt;

  // Cycle counter, cleared before WAIT is entered, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // High during the LIMIT-th WAIT cycle, so the abort lands after exactly LIMIT cycles
  assign expired_c = en && (cnt == WD_W'(LIMIT - 1));

endmodule

// File: rtl/calc_op_sched.sv
// Sequencer between the calculator front-end and the five arithmetic units.
// One operation outstanding at a time: accept, pulse the unit, wait for its
// strobe, hold the result on a valid/ready port.
// Optional: define CALC_TIMEOUT_EN to abort WAIT after TIMEOUT cycles (code 3).
module calc_op_sched
  import calc_pkg::*;
#(
  parameter int unsigned W       = 28,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_W-1:0]       req_op,
  input  logic [W-1:0]          req_a,
  input  logic [W-1:0]          req_b,
  output logic [W-1:0]          u_n1,
  output logic [W-1:0]          u_n2,
  output logic [NUNITS-1:0]     u_valid_in,
  input  logic [NUNITS-1:0]     u_valid_out,
  input  logic [NUNITS-1:0]     u_err,
  input  logic [NUNITS*W-1:0]   u_d_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [W-1:0]          res_data,
  output logic [RC_W-1:0]       res_code,
  output logic                  busy
);

  // The watchdog counter is WD_W bits wide; reject limits it cannot reach
  if ((TIMEOUT < 1) || (TIMEOUT > (2 ** WD_W) - 1)) begin : g_bad_timeout
    $error("calc_op_sched: TIMEOUT out of range");
  end

  state_t            state;
  state_t            state_next;
  logic [OP_W-1:0]   op_q;
  logic [OP_W-1:0]   op_next;
  logic [W-1:0]      n1_next;
  logic [W-1:0]      n2_next;
  logic [NUNITS-1:0] vin_next;
  logic              res_valid_next;
  logic [W-1:0]      res_data_next;
  logic [RC_W-1:0]   res_code_next;
  logic              req_ready_next;
  logic              busy_next;

  logic              sel_strobe_c;
  logic              sel_err_c;
  logic [W-1:0]      sel_data_c;
  logic              wd_expired_c;

`ifdef CALC_TIMEOUT_EN
  calc_watchdog #(
    .LIMIT(TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == S_ISSUE),
    .en        (state == S_WAIT),
    .expired_c (wd_expired_c)
  );
`else
  assign wd_expired_c = 1'b0;
`endif

  // Result mux: pick strobe, error and data of the latched unit only
  always_comb begin
    sel_strobe_c = 1'b0;
    sel_err_c    = 1'b0;
    sel_data_c   = '0;
    for (int k = 0; k < NUNITS; k++) begin
      if (op_q == UNIT_OP[k]) begin
        sel_strobe_c = u_valid_out[k];
        sel_err_c    = u_err[k];
        sel_data_c   = u_d_out[k*W +: W];
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_next     = state;
    op_next        = op_q;
    n1_next        = u_n1;
    n2_next        = u_n2;
    vin_next       = '0;
    res_valid_next = res_valid;
    res_data_next  = res_data;
    res_code_next  = res_code;

    unique case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_next = req_op;
          n1_next = req_a;
          n2_next = req_b;
          if (op_is_legal(req_op)) begin
            state_next = S_ISSUE;
            for (int k = 0; k < NUNITS; k++) begin
              vin_next[k] = (req_op == UNIT_OP[k]);
            end
          end else begin
            state_next     = S_DONE;
            res_valid_next = 1'b1;
            res_data_next  = '0;
            res_code_next  = RC_ILLEGAL;
          end
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (sel_strobe_c) begin
          state_next     = S_DONE;
          res_valid_next = 1'b1;
          res_data_next  = sel_err_c ? '0 : sel_data_c;
          res_code_next  = sel_err_c ? RC_ERR : RC_OK;
        end else if (wd_expired_c) begin
          state_next     = S_DONE;
          res_valid_next = 1'b1;
          res_data_next  = '0;
          res_code_next  = RC_TIMEOUT;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_next     = S_IDLE;
          res_valid_next = 1'b0;
          res_data_next  = '0;
          res_code_next  = RC_OK;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    req_ready_next = (state_next == S_IDLE);
    busy_next      = (state_next != S_IDLE);
  end

  // State and output registers; reset clears everything including req_ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      u_n1       <= '0;
      u_n2       <= '0;
      u_valid_in <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_code   <= RC_OK;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      op_q       <= op_next;
      u_n1       <= n1_next;
      u_n2       <= n2_next;
      u_valid_in <= vin_next;
      res_valid  <= res_valid_next;
      res_data   <= res_data_next;
      res_code   <= res_code_next;
      req_ready  <= req_ready_next;
      busy       <= busy_next;
    end
  end

endmodule
